// File: rtl/down_176.sv
// down_176 -- 176.4 kHz to 88.2 kHz stereo PCM decimator (decimation by 2).
//
// Every input frame (rising edge of ilrck, sampled on pclk) shifts the
// parallel left/right samples into a 7-deep per-channel delay line. Every
// second frame (phase 1) produces one output pair, which appears on
// down_ldata/down_rdata exactly 2 pclk after that frame edge.
//
// Build option:
//   DOWN176_FILTER_EN defined   : halfband FIR, taps -1 0 9 16 9 0 -1 (/32),
//                                 rounded and saturated to DW bits.
//   DOWN176_FILTER_EN undefined : plain decimation, output = newest sample.
//
// Ports:
//   pclk        in   master clock, all logic on its rising edge
//   reset_n     in   asynchronous active-low reset
//   ibick       in   input bit clock (pclk/2), pclk-synchronous
//   ilrck       in   input frame clock, one period per input frame
//   ldata/rdata in   signed DW-bit parallel input samples
//   obick       out  output bit clock, toggles on each ibick rising edge
//   olrck       out  output frame clock: 1 on output load, 0 two pclk after
//                    the following phase-0 frame edge
//   down_ldata  out  signed DW-bit decimated left sample
//   down_rdata  out  signed DW-bit decimated right sample

module down_176 #(
  parameter int DW = 32
) (
  input  logic                 pclk,
  input  logic                 reset_n,
  input  logic                 ibick,
  input  logic                 ilrck,
  input  logic signed [DW-1:0] ldata,
  input  logic signed [DW-1:0] rdata,
  output logic                 obick,
  output logic                 olrck,
  output logic signed [DW-1:0] down_ldata,
  output logic signed [DW-1:0] down_rdata
);

  // Accumulator headroom: sum of |taps| is 36 < 2^6.
  localparam int AW = DW + 6;
  localparam logic signed [AW-1:0] ROUND = AW'(16);
  localparam logic signed [AW-1:0] MAXV  = {7'b0, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV  = ~MAXV;

  logic                 ilrck_q;
  logic                 ibick_q;
  logic                 phase;
  logic                 frame;
  // Frame pulse pipeline: s1 = one pclk after the frame edge, s2 = two.
  logic                 p1_s1, p1_s2;
  logic                 p0_s1, p0_s2;
  logic signed [DW-1:0] dl_l [0:6];
  logic signed [DW-1:0] dl_r [0:6];
  logic signed [AW-1:0] acc_l, acc_r;
  logic signed [AW-1:0] acc_l_next, acc_r_next;

  assign frame = ilrck & ~ilrck_q;

  function automatic logic signed [AW-1:0] sx(input logic signed [DW-1:0] d);
    return {{6{d[DW-1]}}, d};
  endfunction

  // Round half up, divide by 32, clamp to the DW-bit signed range.
  function automatic logic signed [DW-1:0] round_sat(input logic signed [AW-1:0] acc);
    logic signed [AW-1:0] r;
    r = (acc + ROUND) >>> 5;
    if (r > MAXV)
      return MAXV[DW-1:0];
    else if (r < MINV)
      return MINV[DW-1:0];
    else
      return r[DW-1:0];
  endfunction

`ifdef DOWN176_FILTER_EN
  function automatic logic signed [AW-1:0] fir(input logic signed [DW-1:0] d0,
                                               input logic signed [DW-1:0] d2,
                                               input logic signed [DW-1:0] d3,
                                               input logic signed [DW-1:0] d4,
                                               input logic signed [DW-1:0] d6);
    return -sx(d0)
           + (sx(d2) <<< 3) + sx(d2)
           + (sx(d3) <<< 4)
           + (sx(d4) <<< 3) + sx(d4)
           - sx(d6);
  endfunction

  always_comb begin
    acc_l_next = fir(dl_l[0], dl_l[2], dl_l[3], dl_l[4], dl_l[6]);
    acc_r_next = fir(dl_r[0], dl_r[2], dl_r[3], dl_r[4], dl_r[6]);
  end
`else
  // Scale the newest sample by 32 so the shared round/shift stage returns it unchanged.
  always_comb begin
    acc_l_next = sx(dl_l[0]) <<< 5;
    acc_r_next = sx(dl_r[0]) <<< 5;
  end
`endif

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      ilrck_q    <= 1'b0;
      ibick_q    <= 1'b0;
      obick      <= 1'b0;
      phase      <= 1'b0;
      p1_s1      <= 1'b0;
      p1_s2      <= 1'b0;
      p0_s1      <= 1'b0;
      p0_s2      <= 1'b0;
      acc_l      <= '0;
      acc_r      <= '0;
      olrck      <= 1'b0;
      down_ldata <= '0;
      down_rdata <= '0;
      for (int i = 0; i < 7; i++) begin
        dl_l[i] <= '0;
        dl_r[i] <= '0;
      end
    end else begin
      ilrck_q <= ilrck;
      ibick_q <= ibick;
      if (ibick && !ibick_q)
        obick <= ~obick;

      p1_s1 <= frame & phase;
      p0_s1 <= frame & ~phase;
      p1_s2 <= p1_s1;
      p0_s2 <= p0_s1;

      if (frame) begin
        phase   <= ~phase;
        dl_l[0] <= ldata;
        dl_r[0] <= rdata;
        for (int i = 1; i < 7; i++) begin
          dl_l[i] <= dl_l[i-1];
          dl_r[i] <= dl_r[i-1];
        end
      end

      // Delay lines hold the phase-1 frame's samples one pclk after the edge.
      if (p1_s1) begin
        acc_l <= acc_l_next;
        acc_r <= acc_r_next;
      end

      if (p1_s2) begin
        down_ldata <= round_sat(acc_l);
        down_rdata <= round_sat(acc_r);
        olrck      <= 1'b1;
      end else if (p0_s2) begin
        olrck <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_down_176.sv
// Directed testbench for down_176. Expected values are hand-computed for
// the build selected by DOWN176_FILTER_EN (filtered or plain decimation).

module tb_down_176;
  localparam int DW = 32;
  localparam logic signed [DW-1:0] FS = 32'sh7FFF_FFFF;
  localparam logic signed [DW-1:0] DC = 32'sh1000_0000;

  logic                 pclk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 ibick = 1'b0;
  logic                 ilrck = 1'b0;
  logic signed [DW-1:0] ldata = '0;
  logic signed [DW-1:0] rdata = '0;
  logic                 obick;
  logic                 olrck;
  logic signed [DW-1:0] down_ldata;
  logic signed [DW-1:0] down_rdata;

  int checks = 0;
  int failures = 0;

  // Cycle monitor state
  int   cyc = 0;
  int   last_rise = -1;
  int   obick_tog = 0;
  logic last_olrck = 1'b0;
  logic last_obick = 1'b0;
  logic chk_period = 1'b0;

  // Per-frame samples: pre = 1 pclk after frame edge, post = 2 pclk after
  logic signed [DW-1:0] pre_l, post_l, post_r;
  logic                 pre_lr, post_lr;

  down_176 #(.DW(DW)) dut (
    .pclk       (pclk),
    .reset_n    (reset_n),
    .ibick      (ibick),
    .ilrck      (ilrck),
    .ldata      (ldata),
    .rdata      (rdata),
    .obick      (obick),
    .olrck      (olrck),
    .down_ldata (down_ldata),
    .down_rdata (down_rdata)
  );

  // Clock: ~45 MHz
  always #11 pclk = ~pclk;

  task automatic check(input string tag, input logic signed [DW-1:0] got,
                       input logic signed [DW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // One pclk step, sampled at the falling edge.
  task automatic run_cycle();
    @(negedge pclk);
    cyc++;
    if (olrck && !last_olrck) begin
      if (chk_period && last_rise >= 0)
        check("olrck_period", cyc - last_rise, 512);
      last_rise = cyc;
    end
    last_olrck = olrck;
    if (obick !== last_obick)
      obick_tog++;
    last_obick = obick;
  endtask

  // One full 256-pclk input frame carrying samples l/r.
  task automatic frame(input logic signed [DW-1:0] l, input logic signed [DW-1:0] r);
    for (int c = 0; c < 256; c++) begin
      run_cycle();
      if (c == 2) begin
        pre_l  = down_ldata;
        pre_lr = olrck;
      end
      if (c == 3) begin
        post_l  = down_ldata;
        post_r  = down_rdata;
        post_lr = olrck;
      end
      ilrck = (c < 128);
      ibick = c[0];
      if (c == 0) begin
        ldata = l;
        rdata = r;
      end
    end
  endtask

`ifdef DOWN176_FILTER_EN
  int imp1_exp [4] = '{900, 900, -100, 0};
  int imp0_exp [3] = '{0, 1600, 0};
`endif

  initial begin
    // Reset state
    #100;
    check("rst_down_ldata", down_ldata, 0);
    check("rst_down_rdata", down_rdata, 0);
    check("rst_olrck", olrck, 0);
    check("rst_obick", obick, 0);
    @(negedge pclk);
    reset_n = 1'b1;

`ifdef DOWN176_FILTER_EN
    // DC: 3rd output has d6 still zero (33/32 gain), 4th on is exact
    for (int n = 0; n < 10; n++) begin
      frame(DC, DC);
      if (n == 5) check("dc_out3", post_l, 32'sh1080_0000);
      if (n == 7 || n == 9) begin
        check("dc_l", post_l, DC);
        check("dc_r", post_r, DC);
      end
    end
    for (int n = 0; n < 8; n++) frame(0, 0);

    // Phase-1 impulse
    frame(0, 0);
    frame(3200, 0);
    check("imp1_first", post_l, -100);
    check("imp1_r", post_r, 0);
    for (int i = 0; i < 8; i++) begin
      frame(0, 0);
      if (i % 2 == 1) check("imp1_seq", post_l, imp1_exp[i/2]);
    end

    // Phase-0 impulse
    frame(3200, 0);
    for (int i = 0; i < 6; i++) begin
      frame(0, 0);
      if (i % 2 == 0) check("imp0_seq", post_l, imp0_exp[i/2]);
    end
    frame(0, 0);

    // Nyquist: alternating full scale cancels
    for (int i = 0; i < 16; i++) begin
      frame((i % 2 == 0) ? FS : -FS, (i % 2 == 0) ? FS : -FS);
      if (i == 13 || i == 15) begin
        check("nyq_l", post_l, 0);
        check("nyq_r", post_r, 0);
      end
    end

    // Constant full scale: no wrap
    for (int i = 0; i < 8; i++) begin
      frame(FS, FS);
      if (i == 7) begin
        check("fs_l", post_l, FS);
        check("fs_r", post_r, FS);
      end
    end
`else
    // Ramp: outputs are every second sample, 2 pclk after the phase-1 edge
    chk_period = 1'b1;
    last_rise  = -1;
    for (int k = 1; k <= 8; k++) begin
      obick_tog = 0;
      frame(k, -k);
      if (k % 2 == 0) begin
        check("ramp_hold_pre", pre_l, k - 2);
        check("ramp_l", post_l, k);
        check("ramp_r", post_r, -k);
        check("olrck_pre_load", pre_lr, 0);
        check("olrck_load", post_lr, 1);
      end else begin
        check("olrck_pre_clear", pre_lr, (k > 1) ? 1 : 0);
        check("olrck_clear", post_lr, 0);
      end
      if (k >= 2) check("obick_toggles", obick_tog, 128);
    end
    chk_period = 1'b0;

    // Full scale passes unchanged
    frame(FS, -FS);
    frame(FS, -FS);
    check("fs_l", post_l, FS);
    check("fs_r", post_r, -FS);
`endif

    // Freeze: ilrck stops, outputs hold
    for (int i = 0; i < 600; i++) begin
      run_cycle();
      ilrck = 1'b0;
      ibick = ~ibick;
    end
    check("freeze_l", down_ldata, FS);
`ifdef DOWN176_FILTER_EN
    check("freeze_r", down_rdata, FS);
`else
    check("freeze_r", down_rdata, -FS);
`endif
    check("freeze_olrck", olrck, 1);

    // Asynchronous reset mid-stream, well away from a rising edge
    @(negedge pclk);
    #3 reset_n = 1'b0;
    #2;
    check("arst_l", down_ldata, 0);
    check("arst_r", down_rdata, 0);
    check("arst_olrck", olrck, 0);
    #98;
    @(negedge pclk);
    reset_n = 1'b1;
    frame(3200, 3200);
    check("post_rst_frame1", post_l, 0);
    check("post_rst_olrck1", post_lr, 0);
    frame(3200, 3200);
`ifdef DOWN176_FILTER_EN
    check("post_rst_frame2", post_l, -100);
`else
    check("post_rst_frame2", post_l, 3200);
`endif
    check("post_rst_olrck2", post_lr, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
